// File: rtl/mem_ctrl_pkg.sv
// Shared encodings and helpers for the byte-serial memory controller.
package mem_ctrl_pkg;
   localparam logic [1:0] MC_IDLE  = 2'd0;
   localparam logic [1:0] MC_LOAD  = 2'd1;
   localparam logic [1:0] MC_STORE = 2'd2;
   localparam logic [1:0] MC_FETCH = 2'd3;

   localparam logic [1:0] LEN_BYTE = 2'd0;
   localparam logic [1:0] LEN_HALF = 2'd1;
   localparam logic [1:0] LEN_WORD = 2'd2;

   localparam logic [1:0] IO_HI_DEF   = 2'b11;
   localparam int         LSB_CAP_BIT = 3;

   // Latched store request; io marks the back-pressured region.
   typedef struct packed {
      logic        io;
      logic [31:0] wdata;
   } st_req_t;

   function automatic logic [2:0] len_bytes(input logic [1:0] len);
      case (len)
         LEN_BYTE: return 3'd1;
         LEN_HALF: return 3'd2;
         LEN_WORD: return 3'd4;
         default:  return 3'd4;
      endcase
   endfunction

   // Bytes enter the assembly register from the top, so N bytes sit in the upper lanes.
   function automatic logic [31:0] zext_rdata(input logic [31:0] sbuf, input logic [2:0] n);
      case (n)
         3'd1:    return {24'd0, sbuf[31:24]};
         3'd2:    return {16'd0, sbuf[31:16]};
         default: return sbuf;
      endcase
   endfunction

   function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] k);
      return w[{k, 3'b000} +: 8];
   endfunction
endpackage

// File: rtl/mem_ctrl_if.sv
// LSB request/response and instruction-fetch handshake bundle.
interface mem_ctrl_if #(parameter int POS_W = mem_ctrl_pkg::LSB_CAP_BIT);
   logic             lsb_req;
   logic [POS_W-1:0] lsb_pos;
   logic             lsb_ls;
   logic [1:0]       lsb_len;
   logic [31:0]      lsb_addr;
   logic [31:0]      lsb_wdata;
   logic             mem_busy;
   logic             lsb_finished;
   logic [POS_W-1:0] lsb_done_pos;
   logic [31:0]      lsb_rdata;
   logic             if_req;
   logic [31:0]      if_addr;
   logic             if_ready;
   logic [31:0]      if_inst;

   modport master (
      output lsb_req, lsb_pos, lsb_ls, lsb_len, lsb_addr, lsb_wdata, if_req, if_addr,
      input  mem_busy, lsb_finished, lsb_done_pos, lsb_rdata, if_ready, if_inst
   );
   modport slave (
      input  lsb_req, lsb_pos, lsb_ls, lsb_len, lsb_addr, lsb_wdata, if_req, if_addr,
      output mem_busy, lsb_finished, lsb_done_pos, lsb_rdata, if_ready, if_inst
   );
endinterface

// File: rtl/mem_ctrl.sv
// Serialises one LSB load/store or one instruction fetch at a time onto the 8-bit RAM bus.
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter logic [1:0] IO_HI = IO_HI_DEF,
   parameter int         POS_W = LSB_CAP_BIT
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        clear,
   mem_ctrl_if.slave   bus,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   input  logic        io_buffer_full
);
   logic [1:0]       state;
   logic [2:0]       cnt;
   logic [2:0]       nbytes;
   logic [31:0]      sbuf;
   logic [POS_W-1:0] req_pos;
   st_req_t          req;
   logic             busy, finished, ready;
   logic [POS_W-1:0] done_pos;
   logic [31:0]      rdata, inst;
   logic             acc_stall, st_stall;

   assign acc_stall = (bus.lsb_addr[17:16] == IO_HI) && io_buffer_full;
   assign st_stall  = req.io && io_buffer_full;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state    <= MC_IDLE;
         cnt      <= '0;
         nbytes   <= '0;
         sbuf     <= '0;
         req_pos  <= '0;
         req      <= '0;
         busy     <= 1'b0;
         finished <= 1'b0;
         ready    <= 1'b0;
         done_pos <= '0;
         rdata    <= '0;
         inst     <= '0;
         mem_dout <= '0;
         mem_a    <= '0;
         mem_wr   <= 1'b0;
      end else if (rdy_in) begin
         finished <= 1'b0;
         ready    <= 1'b0;
         case (state)
            MC_IDLE: begin
               if (!clear && bus.lsb_req) begin
                  req_pos   <= bus.lsb_pos;
                  req.io    <= (bus.lsb_addr[17:16] == IO_HI);
                  req.wdata <= bus.lsb_wdata;
                  nbytes    <= len_bytes(bus.lsb_len);
                  mem_a     <= bus.lsb_addr;
                  cnt       <= '0;
                  busy      <= 1'b1;
                  if (bus.lsb_ls) begin
                     state    <= MC_STORE;
                     mem_dout <= bus.lsb_wdata[7:0];
                     mem_wr   <= !acc_stall;
                  end else begin
                     state <= MC_LOAD;
                  end
               end else if (!clear && bus.if_req) begin
                  state  <= MC_FETCH;
                  nbytes <= 3'd4;
                  mem_a  <= bus.if_addr;
                  cnt    <= '0;
                  busy   <= 1'b1;
               end
            end
            MC_LOAD, MC_FETCH: begin
               // A flush wins over everything, including the completing edge.
               if (clear) begin
                  state <= MC_IDLE;
                  busy  <= 1'b0;
               end else if (cnt == nbytes) begin
                  state <= MC_IDLE;
                  busy  <= 1'b0;
                  if (state == MC_LOAD) begin
                     finished <= 1'b1;
                     done_pos <= req_pos;
                     rdata    <= zext_rdata(sbuf, nbytes);
                  end else begin
                     ready <= 1'b1;
                     inst  <= sbuf;
                  end
               end else begin
                  sbuf <= {mem_din, sbuf[31:8]};
                  cnt  <= cnt + 3'd1;
                  if (cnt + 3'd1 < nbytes) mem_a <= mem_a + 32'd1;
               end
            end
            MC_STORE: begin
               // mem_wr high means byte cnt is written at this edge; low means it is stalled.
               if (mem_wr) begin
                  if (cnt + 3'd1 < nbytes) begin
                     cnt      <= cnt + 3'd1;
                     mem_a    <= mem_a + 32'd1;
                     mem_dout <= byte_of(req.wdata, cnt[1:0] + 2'd1);
                     mem_wr   <= !st_stall;
                  end else begin
                     mem_wr   <= 1'b0;
                     state    <= MC_IDLE;
                     busy     <= 1'b0;
                     finished <= 1'b1;
                     done_pos <= req_pos;
                  end
               end else if (!st_stall) begin
                  mem_wr <= 1'b1;
               end
            end
            default: state <= MC_IDLE;
         endcase
      end
   end

   assign bus.mem_busy     = busy;
   assign bus.lsb_finished = finished;
   assign bus.lsb_done_pos = done_pos;
   assign bus.lsb_rdata    = rdata;
   assign bus.if_ready     = ready;
   assign bus.if_inst      = inst;
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed vector bench for mem_ctrl with a combinational byte RAM model.
module tb_mem_ctrl;
   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, clear, io_buffer_full;
   logic [7:0]  mem_din, mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic [7:0]  ram [0:255];
   logic [39:0] wlog [$];
   int          tests = 0;
   int          fails = 0;

   mem_ctrl_if #(.POS_W(3)) bus();

   mem_ctrl #(.IO_HI(2'b11), .POS_W(3)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear), .bus(bus),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .io_buffer_full(io_buffer_full)
   );

   always #5 clk_in = ~clk_in;
   assign mem_din = ram[mem_a[7:0]];

   always @(posedge clk_in)
      if (rst_in && rdy_in && mem_wr) begin
         ram[mem_a[7:0]] = mem_dout;
         wlog.push_back({mem_a, mem_dout});
      end

   typedef struct {
      logic        ls;
      logic [1:0]  len;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  pos;
      logic [31:0] exp_rdata;
      int          exp_edge;
   } vec_t;
   vec_t vt [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic start_lsb(input logic ls, input logic [1:0] len, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [2:0] pos);
      bus.lsb_ls = ls; bus.lsb_len = len; bus.lsb_addr = addr;
      bus.lsb_wdata = wdata; bus.lsb_pos = pos; bus.lsb_req = 1'b1;
      step();
      bus.lsb_req = 1'b0;
   endtask

   // Advances until lsb_finished, returning the edge index (accept edge = 0).
   task automatic wait_fin(input int e0, output int e);
      e = e0;
      while (!bus.lsb_finished && e < 40) begin
         step();
         e++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int e, n;
      for (int i = 0; i < 256; i++) ram[i] = i[7:0];
      ram[0] = 8'h78; ram[1] = 8'h56; ram[2] = 8'h34; ram[3] = 8'h12;
      rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
      bus.lsb_req = 1'b0; bus.lsb_pos = '0; bus.lsb_ls = 1'b0; bus.lsb_len = '0;
      bus.lsb_addr = '0; bus.lsb_wdata = '0; bus.if_req = 1'b0; bus.if_addr = '0;

      vt[0] = '{1'b0, 2'd2, 32'h0000_0100, 32'h0,         3'd3, 32'h1234_5678, 5};
      vt[1] = '{1'b0, 2'd1, 32'h0000_0112, 32'h0,         3'd1, 32'h0000_1312, 3};
      vt[2] = '{1'b0, 2'd0, 32'h0000_01FF, 32'h0,         3'd2, 32'h0000_00FF, 2};
      vt[3] = '{1'b1, 2'd1, 32'h0000_0204, 32'hAABB_CCDD, 3'd5, 32'h0,         2};
      vt[4] = '{1'b1, 2'd2, 32'h0000_0020, 32'h1122_3344, 3'd6, 32'h0,         4};
      vt[5] = '{1'b0, 2'd2, 32'h0000_0020, 32'h0,         3'd7, 32'h1122_3344, 5};
      vt[6] = '{1'b1, 2'd0, 32'h0000_0051, 32'h0000_007E, 3'd0, 32'h0,         1};
      vt[7] = '{1'b0, 2'd2, 32'hFFFF_FFFE, 32'h0,         3'd4, 32'h5678_FFFE, 5};
      vt[8] = '{1'b1, 2'd0, 32'h0003_0080, 32'h0000_005A, 3'd2, 32'h0,         1};

      step();
      chk("rst_busy", {31'd0, bus.mem_busy}, 0);
      chk("rst_outs", {30'd0, mem_wr, bus.lsb_finished}, 0);
      chk("rst_addr", mem_a, 0);
      chk("rst_rdata", bus.lsb_rdata | bus.if_inst | {24'd0, mem_dout}, 0);
      step();
      rst_in = 1'b1;
      step();

      for (int i = 0; i < 9; i++) begin
         n = (vt[i].len == 2'd0) ? 1 : (vt[i].len == 2'd1) ? 2 : 4;
         wlog.delete();
         start_lsb(vt[i].ls, vt[i].len, vt[i].addr, vt[i].wdata, vt[i].pos);
         chk($sformatf("v%0d_busy", i), {31'd0, bus.mem_busy}, 1);
         wait_fin(0, e);
         chk($sformatf("v%0d_edge", i), e, vt[i].exp_edge);
         chk($sformatf("v%0d_pos", i), {29'd0, bus.lsb_done_pos}, {29'd0, vt[i].pos});
         chk($sformatf("v%0d_idle", i), {31'd0, bus.mem_busy}, 0);
         if (!vt[i].ls) chk($sformatf("v%0d_rdata", i), bus.lsb_rdata, vt[i].exp_rdata);
         else begin
            chk($sformatf("v%0d_nwr", i), wlog.size(), n);
            for (int k = 0; k < n && k < wlog.size(); k++) begin
               chk($sformatf("v%0d_wa%0d", i, k), wlog[k][39:8], vt[i].addr + k);
               chk($sformatf("v%0d_wd%0d", i, k), {24'd0, wlog[k][7:0]},
                   {24'd0, vt[i].wdata[8*k +: 8]});
            end
         end
         step();
      end

      // Arbitration: load wins, fetch is taken the cycle busy falls.
      bus.if_addr = 32'h40; bus.if_req = 1'b1;
      start_lsb(1'b0, 2'd0, 32'h10, 32'h0, 3'd4);
      wait_fin(0, e);
      chk("arb_ld_edge", e, 2);
      chk("arb_ld_rdata", bus.lsb_rdata, 32'h10);
      chk("arb_no_early_if", {31'd0, bus.if_ready}, 0);
      step(); e++;
      chk("arb_if_acc", {bus.mem_busy, mem_a[30:0]}, {1'b1, 31'h40});
      while (!bus.if_ready && e < 40) begin step(); e++; end
      bus.if_req = 1'b0;
      chk("arb_if_edge", e, 8);
      chk("arb_if_inst", bus.if_inst, 32'h4342_4140);
      step();
      chk("arb_if_idle", {31'd0, bus.mem_busy}, 0);

      // IO store back-pressure.
      wlog.delete();
      io_buffer_full = 1'b1;
      start_lsb(1'b1, 2'd0, 32'h0003_0000, 32'h41, 3'd1);
      chk("io_hold0", {31'd0, mem_wr}, 0);
      step(); chk("io_hold1", {31'd0, mem_wr}, 0);
      step(); chk("io_hold2", {31'd0, mem_wr}, 0);
      io_buffer_full = 1'b0;
      step();
      chk("io_wr", {mem_wr, 23'd0, mem_dout}, {1'b1, 23'd0, 8'h41});
      chk("io_addr", mem_a, 32'h0003_0000);
      chk("io_no_fin", {31'd0, bus.lsb_finished}, 0);
      step();
      chk("io_fin", {30'd0, bus.lsb_finished, mem_wr}, 2);
      chk("io_nwr", wlog.size(), 1);
      step();

      // Flush during a byte load.
      start_lsb(1'b0, 2'd0, 32'h11, 32'h0, 3'd2);
      clear = 1'b1; step(); clear = 1'b0;
      chk("clr_ld_busy", {31'd0, bus.mem_busy}, 0);
      n = 0;
      for (int k = 0; k < 3; k++) begin
         n += bus.lsb_finished;
         step();
      end
      chk("clr_ld_nofin", n, 0);

      // Flush coinciding with the completing edge.
      start_lsb(1'b0, 2'd0, 32'h12, 32'h0, 3'd3);
      step();
      clear = 1'b1; step(); clear = 1'b0;
      chk("clr_fin_supp", {30'd0, bus.lsb_finished, bus.mem_busy}, 0);
      step();

      // No accept while clear is high.
      clear = 1'b1;
      start_lsb(1'b0, 2'd0, 32'h13, 32'h0, 3'd3);
      clear = 1'b0;
      chk("clr_no_acc", {31'd0, bus.mem_busy}, 0);
      step();

      // Flush does not abort a committed store.
      wlog.delete();
      start_lsb(1'b1, 2'd2, 32'h60, 32'hDEAD_BEEF, 3'd6);
      step();
      clear = 1'b1; step(); clear = 1'b0;
      wait_fin(2, e);
      chk("clr_st_edge", e, 4);
      chk("clr_st_nwr", wlog.size(), 4);
      if (wlog.size() == 4) begin
         chk("clr_st_first", wlog[0], {32'h60, 8'hEF});
         chk("clr_st_last", wlog[3], {32'h63, 8'hDE});
      end
      step();

      // Asynchronous reset mid-store.
      start_lsb(1'b1, 2'd2, 32'h70, 32'h0102_0304, 3'd5);
      step();
      #2 rst_in = 1'b0;
      #1;
      chk("arst_ctl", {29'd0, bus.mem_busy, mem_wr, bus.lsb_finished}, 0);
      chk("arst_bus", mem_a | {24'd0, mem_dout}, 0);
      step();
      rst_in = 1'b1;
      step();
      chk("arst_idle", {31'd0, bus.mem_busy}, 0);

      // Pause mid-load.
      start_lsb(1'b0, 2'd2, 32'h40, 32'h0, 3'd5);
      step(); step();
      chk("rdy_pre_a", mem_a, 32'h42);
      rdy_in = 1'b0;
      step(); step(); step();
      chk("rdy_hold_a", mem_a, 32'h42);
      chk("rdy_hold", {30'd0, bus.mem_busy, bus.lsb_finished}, 2);
      rdy_in = 1'b1;
      wait_fin(2, e);
      chk("rdy_edge", e, 5);
      chk("rdy_rdata", bus.lsb_rdata, 32'h4342_4140);
      chk("rdy_pos", {29'd0, bus.lsb_done_pos}, 5);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
